row_transfer_engine: RTL and testbench

Parametrised engine that moves one display row between a wide on-chip row register and the word-wide burst memory controller. It performs a write-back of a computed row, a fetch of a stored row, or both back-to-back, one word per acknowledge. It inserts periodic refresh requests during long transfers. It sits between the Game of Life row calculator and the DDR controller, replacing the hand-unrolled per-word case logic with a counter-driven sequencer.

---
 rtl/gol_mem_pkg.sv | 24 ++
 rtl/row_transfer_engine_refresh_scheduler.sv | 39 +++
 rtl/row_transfer_engine.sv | 140 ++++++++++++++
 tb/tb_row_transfer_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_mem_pkg.sv
// Shared types and helpers for the row <-> burst-memory transfer path.
// State encoding, default row geometry and word-address packing.
package gol_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    FINISH
  } state_t;

  localparam int ROW_BITS_DEF  = 640;
  localparam int WORD_BITS_DEF = 16;
  localparam int WORDS = ROW_BITS_DEF / WORD_BITS_DEF;

  function automatic logic [31:0] pack_addr(
    input logic [31:0] row,
    input logic [31:0] off,
    input int          off_bits
  );
    return (row << off_bits) | off;
  endfunction

endpackage

// File: rtl/row_transfer_engine_refresh_scheduler.sv
// Refresh request flag, raised at operation start and every
// INTERVAL acknowledged words; cleared by the controller's ack.
module refresh_scheduler #(
  parameter int INTERVAL = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic word_ack,
  input  logic refresh_ack,
  output logic refresh
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [CW-1:0] cnt;
  logic          hit;

  assign hit = (INTERVAL > 0) && word_ack &&
               (int'(cnt) == INTERVAL - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      refresh <= 1'b0;
    end else begin
      if (start)
        cnt <= '0;
      else if (word_ack)
        cnt <= hit ? '0 : cnt + 1'b1;
      // a new request wins over a same-cycle ack
      if (start || hit)
        refresh <= 1'b1;
      else if (refresh_ack)
        refresh <= 1'b0;
    end
  end

endmodule

// File: rtl/row_transfer_engine.sv
// Moves one display row to/from burst memory, one word per ack.
// Optional READ_SHADOW_EN: read_row updates atomically at completion.
module row_transfer_engine
  import gol_mem_pkg::*;
#(
  parameter int ROW_BITS         = 640,
  parameter int WORD_BITS        = 16,
  parameter int ADDR_BITS        = 24,
  parameter int ROW_INDEX_BITS   = 9,
  parameter int OFFSET_BITS      = 6,
  parameter int REFRESH_INTERVAL = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_write,
  input  logic                      start_read,
  input  logic [ROW_INDEX_BITS-1:0] wr_row_index,
  input  logic [ROW_INDEX_BITS-1:0] rd_row_index,
  input  logic [ROW_BITS-1:0]       write_row,
  output logic [ROW_BITS-1:0]       read_row,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_write,
  input  logic                      mem_write_ack,
  output logic [ADDR_BITS-1:0]      mem_write_addr,
  output logic [WORD_BITS-1:0]      mem_write_data,
  output logic                      mem_read,
  input  logic                      mem_read_ack,
  output logic [ADDR_BITS-1:0]      mem_read_addr,
  input  logic [WORD_BITS-1:0]      mem_read_data,
  output logic                      refresh,
  input  logic                      refresh_ack
);

  localparam int NW = ROW_BITS / WORD_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST =
    OFFSET_BITS'(NW - 1);

  state_t                    state, state_nxt;
  logic [OFFSET_BITS-1:0]    off;
  logic                      both;
  logic [ROW_INDEX_BITS-1:0] wr_row, rd_row;
  logic                      go, wr_ack, rd_ack, last;

  assign go     = (state == IDLE) && (start_write || start_read);
  assign wr_ack = (state == WRITE) && mem_write_ack;
  assign rd_ack = (state == READ) && mem_read_ack;
  assign last   = (off == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_write)     state_nxt = WRITE;
        else if (start_read) state_nxt = READ;
      end
      WRITE:
        if (wr_ack && last)
          state_nxt = both ? READ : FINISH;
      READ:
        if (rd_ack && last) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      off    <= '0;
      both   <= 1'b0;
      wr_row <= '0;
      rd_row <= '0;
    end else if (state == IDLE) begin
      off <= '0;
      if (go) begin
        both   <= start_write && start_read;
        wr_row <= wr_row_index;
        rd_row <= rd_row_index;
      end
    end else if (wr_ack || rd_ack) begin
      // wraps to 0 so a following read phase starts at word 0
      off <= last ? '0 : off + 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign mem_write = (state == WRITE);
  assign mem_read  = (state == READ);

  assign mem_write_addr = mem_write ?
    ADDR_BITS'(pack_addr(32'(wr_row), 32'(off), OFFSET_BITS)) : '0;
  assign mem_read_addr = mem_read ?
    ADDR_BITS'(pack_addr(32'(rd_row), 32'(off), OFFSET_BITS)) : '0;
  assign mem_write_data = mem_write ?
    write_row[int'(off)*WORD_BITS +: WORD_BITS] : '0;

`ifdef READ_SHADOW_EN
  logic [ROW_BITS-1:0] shadow, shadow_nxt;

  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[int'(off)*WORD_BITS +: WORD_BITS] = mem_read_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow   <= '0;
      read_row <= '0;
    end else if (rd_ack) begin
      shadow <= shadow_nxt;
      if (last) read_row <= shadow_nxt;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      read_row <= '0;
    else if (rd_ack)
      read_row[int'(off)*WORD_BITS +: WORD_BITS] <= mem_read_data;
  end
`endif

  refresh_scheduler #(
    .INTERVAL(REFRESH_INTERVAL)
  ) u_refresh (
    .clk         (clk),
    .rst         (rst),
    .start       (go),
    .word_ack    (wr_ack || rd_ack),
    .refresh_ack (refresh_ack),
    .refresh     (refresh)
  );

endmodule

// File: tb/tb_row_transfer_engine.sv
// Directed bench for row_transfer_engine: write, read, combined,
// refresh cadence, busy-start rejection and mid-read reset.
module tb_row_transfer_engine;

  localparam int RB = 640;
  localparam int WB = 16;
  localparam int AB = 24;
  localparam int NW = RB / WB;

  logic          clk;
  logic          rst;
  logic          start_write, start_read;
  logic [8:0]    wr_row_index, rd_row_index;
  logic [RB-1:0] write_row, read_row, exp_row;
  logic          busy, done;
  logic          mem_write, mem_write_ack;
  logic [AB-1:0] mem_write_addr;
  logic [WB-1:0] mem_write_data;
  logic          mem_read, mem_read_ack;
  logic [AB-1:0] mem_read_addr;
  logic [WB-1:0] mem_read_data;
  logic          refresh, refresh_ack;

  int n_cmp = 0;
  int n_bad = 0;
  int dcnt;
  logic ref_exp;

  row_transfer_engine dut (
    .clk            (clk),
    .rst            (rst),
    .start_write    (start_write),
    .start_read     (start_read),
    .wr_row_index   (wr_row_index),
    .rd_row_index   (rd_row_index),
    .write_row      (write_row),
    .read_row       (read_row),
    .busy           (busy),
    .done           (done),
    .mem_write      (mem_write),
    .mem_write_ack  (mem_write_ack),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_read_ack   (mem_read_ack),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .refresh        (refresh),
    .refresh_ack    (refresh_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [RB-1:0] obs,
                         input logic [RB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] word_of(input logic [RB-1:0] r,
                                            input int k);
    return r[k*WB +: WB];
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mwr"}, 32'(mem_write), 0);
    chk({tag, "_mrd"}, 32'(mem_read), 0);
    chk({tag, "_wad"}, 32'(mem_write_addr), 0);
    chk({tag, "_rad"}, 32'(mem_read_addr), 0);
    chk({tag, "_wdat"}, 32'(mem_write_data), 0);
    chk({tag, "_ref"}, 32'(refresh), 0);
    chk_row({tag, "_row"}, read_row, '0);
  endtask

  initial begin
    rst = 1'b0;
    start_write = 1'b0;
    start_read = 1'b0;
    wr_row_index = '0;
    rd_row_index = '0;
    write_row = '0;
    mem_write_ack = 1'b0;
    mem_read_ack = 1'b0;
    mem_read_data = '0;
    refresh_ack = 1'b0;
    for (int k = 0; k < NW; k++) write_row[k*WB +: WB] = 16'hA5A5;
    repeat (3) tick();
    chk_all_zero("rst");
    rst = 1'b1;
    tick();

    // single write to row 5, ack every cycle
    for (int k = 0; k < NW; k++) write_row[k*WB +: WB] = 16'hA000 + 16'(k);
    wr_row_index = 9'd5;
    start_write = 1'b1;
    tick();
    start_write = 1'b0;
    chk("wr_busy", 32'(busy), 1);
    chk("wr_ref_entry", 32'(refresh), 1);
    mem_write_ack = 1'b1;
    for (int k = 0; k < NW; k++) begin
      chk("wr_req", 32'(mem_write), 1);
      chk("wr_addr", 32'(mem_write_addr), 32'h140 + 32'(k));
      chk("wr_data", 32'(mem_write_data), 32'hA000 + 32'(k));
      chk("wr_no_rd", 32'(mem_read), 0);
      chk("wr_no_done", 32'(done), 0);
      start_read = (k == 10);
      tick();
    end
    mem_write_ack = 1'b0;
    chk("wr_done", 32'(done), 1);
    chk("wr_req_drop", 32'(mem_write), 0);
    tick();
    chk("wr_done_pulse", 32'(done), 0);
    chk("wr_idle", 32'(busy), 0);
    chk("wr_ign_rd", 32'(mem_read), 0);
    tick();
    chk("wr_idle2", 32'(busy), 0);

    // single read from row 479, ack every third cycle
    rd_row_index = 9'd479;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    for (int k = 0; k < NW; k++) exp_row[k*WB +: WB] = 16'h0100 + 16'(k);
    for (int k = 0; k < NW; k++) begin
      chk("rd_req", 32'(mem_read), 1);
      chk("rd_addr", 32'(mem_read_addr), 32'h77C0 + 32'(k));
      tick();
      chk("rd_addr_hold", 32'(mem_read_addr), 32'h77C0 + 32'(k));
      tick();
      mem_read_ack = 1'b1;
      mem_read_data = 16'h0100 + 16'(k);
      tick();
      mem_read_ack = 1'b0;
      mem_read_data = '0;
      if (k < NW - 1) begin
`ifdef READ_SHADOW_EN
        chk("rd_shadow_hold", 32'(word_of(read_row, k)), 0);
`else
        chk("rd_word", 32'(word_of(read_row, k)), 32'h0100 + 32'(k));
`endif
      end
    end
    chk("rd_done", 32'(done), 1);
    chk("rd_req_drop", 32'(mem_read), 0);
    chk_row("rd_row", read_row, exp_row);
    tick();
    chk("rd_idle", 32'(busy), 0);

    // combined write row 2 + read row 4 with refresh cadence
    for (int k = 0; k < NW; k++) write_row[k*WB +: WB] = 16'hC300 + 16'(k);
    wr_row_index = 9'd2;
    rd_row_index = 9'd4;
    mem_write_ack = 1'b1;
    mem_read_ack = 1'b1;
    start_write = 1'b1;
    start_read = 1'b1;
    tick();
    start_write = 1'b0;
    start_read = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 2 * NW; i++) begin
      ref_exp = (i <= 2) || (i >= 18 && i <= 20) ||
                (i >= 36 && i <= 44) || (i >= 54 && i <= 56) ||
                (i >= 72);
      chk("cb_refresh", 32'(refresh), 32'(ref_exp));
      if (i < NW) begin
        chk("cb_wr_req", 32'(mem_write), 1);
        chk("cb_wr_addr", 32'(mem_write_addr), 32'h80 + 32'(i));
        chk("cb_wr_data", 32'(mem_write_data), 32'hC300 + 32'(i));
        chk("cb_wr_no_rd", 32'(mem_read), 0);
      end else begin
        chk("cb_rd_req", 32'(mem_read), 1);
        chk("cb_rd_addr", 32'(mem_read_addr), 32'h100 + 32'(i - NW));
        chk("cb_rd_no_wr", 32'(mem_write), 0);
        mem_read_data = 16'h5500 + 16'(i - NW);
      end
      if (done) dcnt++;
      refresh_ack = (i == 2) || (i == 20) || (i == 44) ||
                    (i == 56) || (i == 71);
      tick();
    end
    refresh_ack = 1'b0;
    for (int k = 0; k < NW; k++) exp_row[k*WB +: WB] = 16'h5500 + 16'(k);
    chk("cb_done", 32'(done), 1);
    chk("cb_ref_hold", 32'(refresh), 1);
    chk_row("cb_row", read_row, exp_row);
    if (done) dcnt++;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (done) dcnt++;
      chk("cb_idle", 32'(busy), 0);
      chk("cb_idle_rd", 32'(mem_read), 0);
      chk("cb_idle_wr", 32'(mem_write), 0);
    end
    chk("cb_one_done", 32'(dcnt), 1);
    mem_write_ack = 1'b0;
    mem_read_ack = 1'b0;
    refresh_ack = 1'b1;
    tick();
    refresh_ack = 1'b0;
    chk("cb_ref_clear", 32'(refresh), 0);

    // reset asserted at word 20 of a read
    rd_row_index = 9'd7;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    mem_read_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_read_data = 16'h0E00 + 16'(i);
      tick();
    end
    chk("ab_busy_pre", 32'(busy), 1);
    chk("ab_addr_pre", 32'(mem_read_addr), 32'h1C0 + 32'd20);
    rst = 1'b0;
    #1;
    chk_all_zero("ab");
    mem_read_ack = 1'b0;
    mem_read_data = '0;
    tick();
    rst = 1'b1;
    tick();
    chk("ab_idle", 32'(busy), 0);

    // fresh write to row 1 after the abort
    wr_row_index = 9'd1;
    start_write = 1'b1;
    tick();
    start_write = 1'b0;
    mem_write_ack = 1'b1;
    for (int k = 0; k < NW; k++) begin
      chk("re_addr", 32'(mem_write_addr), 32'h40 + 32'(k));
      chk("re_data", 32'(mem_write_data), 32'hC300 + 32'(k));
      tick();
    end
    mem_write_ack = 1'b0;
    chk("re_done", 32'(done), 1);
    tick();
    chk("re_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
